// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over a
// request/response memory port and hands it to decode with a valid/ready handshake.
module ysyx_23060096_ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] inst_pc_n;
    logic [31:0]     inst_n;
    logic            drop, drop_n;
    logic [XLEN-1:0] target;
    logic            req_fire;

    assign target         = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc;
    assign inst_valid     = (state == S_HOLD);
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_BOOT;
            pc      <= RESET_PC;
            drop    <= 1'b0;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            drop    <= drop_n;
            inst    <= inst_n;
            inst_pc <= inst_pc_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        drop_n    = drop;
        inst_n    = inst;
        inst_pc_n = inst_pc;
        case (state)
            S_BOOT: begin
                state_n = S_REQ;
                if (redirect_valid) pc_n = target;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_n = target;
                    // The old address is already in flight; its word must be thrown away.
                    if (req_fire) begin
                        drop_n  = 1'b1;
                        state_n = S_WAIT;
                    end
                end else if (req_fire) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_n = target;
                    if (imem_rsp_valid) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        drop_n = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        inst_n    = imem_rsp_data;
                        inst_pc_n = pc;
                        state_n   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = S_REQ;
                end else if (inst_ready) begin
                    pc_n    = pc + XLEN'(4);
                    state_n = S_REQ;
                end
            end
            default: state_n = S_BOOT;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Randomized bench for the fetch unit: a latency-randomised memory and a PC-level
// reference model (next PC = redirect target or PC+4 on consume) check every cycle.
module tb_ysyx_23060096_ifu;

    localparam logic [31:0] RST_PC  = 32'h8000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        inst_valid, inst_ready, redirect_valid;
    logic [31:0] inst, inst_pc, redirect_pc;
    logic        w_req_valid, w_inst_valid;
    logic [31:0] w_addr, w_inst, w_inst_pc;

    ysyx_23060096_ifu #(.XLEN(32), .RESET_PC(RST_PC)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Same inputs, different reset PC: runs in lockstep with u_dut for the wrap test.
    ysyx_23060096_ifu #(.XLEN(32), .RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(w_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(w_inst_valid),
        .inst_ready(inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    int          consumed = 0;
    int          p_memready = 100, p_redir = 0, dly_max = 0, ready_mode = 1;
    bit          mem_hold = 0, force_redir = 0, pending = 0;
    int          cnt = 0;
    logic [31:0] force_tgt = '0, model_pc = RST_PC, paddr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0513;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
    endfunction

    // One clock: check outputs against the model, drive memory/decode/redirect, advance model.
    task automatic cycle();
        @(negedge clk);
        if (rst_n) begin
            total++;
            if (inst_valid && imem_req_valid) $display("FAIL overlap: inst_valid=1 req_valid=1, required not both");
            else passed++;
            if (imem_req_valid) begin
                total++;
                if (imem_addr !== model_pc) $display("FAIL req_addr: got %h expected %h", imem_addr, model_pc);
                else passed++;
            end
            if (inst_valid) begin
                total++;
                if (inst_pc !== model_pc || inst !== memf(model_pc))
                    $display("FAIL inst: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, model_pc, memf(model_pc));
                else passed++;
            end
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (pending) begin
            if (!mem_hold) begin
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memf(paddr);
                    pending        = 1'b0;
                end else cnt--;
            end
        end else if ($urandom_range(0, 99) < 10) imem_rsp_valid = 1'b1;
        imem_req_ready = ($urandom_range(0, 99) < p_memready);
        if (imem_req_valid && imem_req_ready) begin
            pending = 1'b1;
            paddr   = imem_addr;
            cnt     = $urandom_range(0, dly_max);
        end
        inst_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
        redirect_valid = force_redir || ($urandom_range(0, 99) < p_redir);
        redirect_pc    = force_redir ? force_tgt : {16'h8000, 16'($urandom)};
        if (inst_valid && inst_ready) consumed++;
        if (redirect_valid) model_pc = {redirect_pc[31:2], 2'b00};
        else if (inst_valid && inst_ready) model_pc = model_pc + 32'd4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; inst_ready = 0; redirect_valid = 0;
        pending = 0;
        repeat (2) @(negedge clk);
        model_pc = RST_PC;
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (imem_req_valid) begin ok = 1; break; end
        end
        if (!ok) begin total++; $display("FAIL %s_timeout: no request within 200 cycles", name); end
    endtask

    task automatic wait_inst(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (inst_valid) begin ok = 1; break; end
        end
        if (!ok) begin total++; $display("FAIL %s_timeout: no inst_valid within 200 cycles", name); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; inst_ready = 0; redirect_valid = 0;
        #1;
        total++;
        if (imem_req_valid !== 0 || inst_valid !== 0 || inst !== 0 || inst_pc !== 0)
            $display("FAIL reset_outputs: got req=%b ival=%b inst=%h pc=%h expected 0", imem_req_valid, inst_valid, inst, inst_pc);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1; pending = 0; model_pc = RST_PC;
        total++;
        if (imem_req_valid !== 1'b0) $display("FAIL boot_idle: got req_valid=%b expected 0", imem_req_valid);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL boot_to_req: got req=%b addr=%h expected 1 %h", imem_req_valid, imem_addr, RST_PC);
        else passed++;
    endtask

    task automatic test_first_fetch();
        p_memready = 100; dly_max = 0; ready_mode = 1; p_redir = 0;
        wait_inst("first_fetch");
        total++;
        if (inst !== 32'h0000_0513 || inst_pc !== RST_PC)
            $display("FAIL first_inst: got inst=%h pc=%h expected 00000513 %h", inst, inst_pc, RST_PC);
        else passed++;
        wait_req("first_fetch");
        total++;
        if (imem_addr !== 32'h8000_0004) $display("FAIL second_addr: got %h expected 80000004", imem_addr);
        else passed++;
    endtask

    task automatic test_hold_stall();
        logic [31:0] i0, p0;
        ready_mode = 0;
        wait_inst("hold");
        i0 = inst; p0 = inst_pc;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++;
            if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || inst !== i0 || inst_pc !== p0)
                $display("FAIL hold_stable: got ival=%b req=%b inst=%h pc=%h expected 1 0 %h %h", inst_valid, imem_req_valid, inst, inst_pc, i0, p0);
            else passed++;
        end
        ready_mode = 1;
        cycle();
    endtask

    task automatic test_redirect_wait();
        bit ok = 0;
        ready_mode = 1; dly_max = 2; p_memready = 100;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (pending) begin ok = 1; break; end
        end
        if (!ok) begin total++; $display("FAIL redir_wait_timeout: no request accepted"); end
        force_redir = 1; force_tgt = 32'h8000_0103;
        cycle();
        force_redir = 0;
        wait_req("redir_wait");
        total++;
        if (imem_addr !== 32'h8000_0100) $display("FAIL redir_wait_addr: got %h expected 80000100", imem_addr);
        else passed++;
        wait_inst("redir_wait");
        total++;
        if (inst_pc !== 32'h8000_0100 || inst !== memf(32'h8000_0100))
            $display("FAIL redir_wait_inst: got pc=%h inst=%h expected 80000100 %h", inst_pc, inst, memf(32'h8000_0100));
        else passed++;
    endtask

    task automatic test_redirect_hold();
        ready_mode = 0;
        wait_inst("redir_hold");
        ready_mode = 1; force_redir = 1; force_tgt = 32'h8000_0040;
        cycle();
        force_redir = 0;
        wait_req("redir_hold");
        total++;
        if (imem_addr !== 32'h8000_0040) $display("FAIL redir_hold_addr: got %h expected 80000040", imem_addr);
        else passed++;
    endtask

    task automatic test_pc_wrap();
        bit ok;
        do_reset();
        p_memready = 100; dly_max = 1; ready_mode = 1; p_redir = 0;
        wait_req("wrap");
        total++;
        if (w_req_valid !== 1'b1 || w_addr !== WRAP_PC) $display("FAIL wrap_first_addr: got %h expected fffffffc", w_addr);
        else passed++;
        wait_inst("wrap");
        total++;
        if (w_inst_valid !== 1'b1 || w_inst_pc !== WRAP_PC) $display("FAIL wrap_inst_pc: got %h expected fffffffc", w_inst_pc);
        else passed++;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (w_req_valid) begin ok = 1; break; end
        end
        total++;
        if (!ok || w_addr !== 32'h0) $display("FAIL wrap_next_addr: got %h expected 00000000", w_addr);
        else passed++;
    endtask

    task automatic test_reset_in_wait();
        bit ok = 0;
        p_memready = 100; dly_max = 0; ready_mode = 1; mem_hold = 1;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (pending) begin ok = 1; break; end
        end
        if (!ok) begin total++; $display("FAIL rst_wait_timeout: no request accepted"); end
        cycle();
        rst_n = 1'b0; p_memready = 0;
        #1;
        total++;
        if (imem_req_valid !== 0 || inst_valid !== 0 || inst_pc !== 0)
            $display("FAIL rst_wait_async: got req=%b ival=%b pc=%h expected 0 0 0", imem_req_valid, inst_valid, inst_pc);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1; model_pc = RST_PC; mem_hold = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            total++;
            if (inst_valid !== 1'b0) $display("FAIL rst_stale_rsp: got inst_valid=%b expected 0", inst_valid);
            else passed++;
        end
        p_memready = 100;
        wait_inst("rst_wait");
        total++;
        if (inst_pc !== RST_PC || inst !== 32'h0000_0513)
            $display("FAIL rst_restart: got pc=%h inst=%h expected %h 00000513", inst_pc, inst, RST_PC);
        else passed++;
    endtask

    task automatic test_random();
        int c0;
        p_memready = 60; dly_max = 3; ready_mode = 2; p_redir = 0;
        c0 = consumed;
        repeat (400) cycle();
        total++;
        if (consumed - c0 < 20) $display("FAIL progress: got %0d consumed expected at least 20", consumed - c0);
        else passed++;
        p_redir = 6;
        repeat (3000) cycle();
        p_redir = 0;
        c0 = consumed;
        repeat (200) cycle();
        total++;
        if (consumed - c0 < 10) $display("FAIL progress_after_redirects: got %0d expected at least 10", consumed - c0);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_first_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_random();
        test_pc_wrap();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
